// File: rtl/mem_wb.sv
// MEM/WB stage: drives one data-memory access per load/store and writes
// the ALU or load result back to the register file.
//
// Ports:
//   clk, reset (async, active-low)
//   ex_valid_i/ex_ready_o   : EX handshake; ready only while idle
//   alu_result_i, r2_data_i : address or ALU result, store data
//   writebackaddr_i, funct3_i, is_load_i, is_store_i, reg_write_i
//   dmem_*                  : req/gnt request phase, rvalid/rdata response
//   w_addr, w_data, wb_en   : register-file write port
//   misalign_o              : one-cycle trap pulse (MISALIGN_TRAP_EN only)
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module mem_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] r2_data_i,
  input  logic [4:0]  writebackaddr_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        reg_write_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        wb_en
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] r2_q, r2_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic        st_q, st_d;
  logic        rw_q, rw_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic        req;

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic mis_in;

  assign mis_in = (is_load_i | is_store_i) &
                  (((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                   ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0])));
  assign misalign_o = mis_q;
`endif

  // Store lane steering; low address bits beyond the access size
  // are simply dropped.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = '0;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00): begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{r2_q[7:0]}};
      end
      (f3_q[1:0] == 2'b01): begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{r2_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = r2_q;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_b = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_h = addr_q[1] ? dmem_rdata_i[31:16]
                     : dmem_rdata_i[15:0];
    unique case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_val = {24'b0, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_val = {16'b0, ld_h};
      default: ld_val = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    r2_d    = r2_q;
    res_d   = res_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    st_d    = st_q;
    rw_d    = rw_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          addr_d = alu_result_i;
          r2_d   = r2_data_i;
          res_d  = alu_result_i;
          rd_d   = writebackaddr_i;
          f3_d   = funct3_i;
          st_d   = is_store_i;
          rw_d   = reg_write_i;
          if (is_load_i | is_store_i)
            state_d = S_REQ;
          else
            state_d = S_WB;
`ifdef MISALIGN_TRAP_EN
          if (mis_in) begin
            state_d = S_IDLE;
            rw_d    = 1'b0;
            mis_d   = 1'b1;
          end
`endif
        end
      end
      S_REQ: begin
        if (dmem_gnt_i)
          state_d = st_q ? S_IDLE : S_RSP;
      end
      S_RSP: begin
        if (dmem_rvalid_i) begin
          res_d   = ld_val;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      r2_q    <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      st_q    <= 1'b0;
      rw_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      r2_q    <= r2_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      st_q    <= st_d;
      rw_q    <= rw_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign req          = (state_q == S_REQ);
  assign ex_ready_o   = (state_q == S_IDLE);
  assign dmem_req_o   = req;
  assign dmem_we_o    = req & st_q;
  assign dmem_addr_o  = req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_be_o    = req ? (st_q ? st_be : 4'b1111)
                            : 4'b0000;
  assign dmem_wdata_o = (req & st_q) ? st_wdata : '0;

  // x0 is never written even if the instruction claims it.
  assign wb_en  = (state_q == S_WB) & rw_q & (|rd_q);
  assign w_addr = rd_q;
  assign w_data = res_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for mem_wb.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mem_wb;

  logic        clk;
  logic        reset;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] alu_result_i;
  logic [31:0] r2_data_i;
  logic [4:0]  writebackaddr_i;
  logic [2:0]  funct3_i;
  logic        is_load_i;
  logic        is_store_i;
  logic        reg_write_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        wb_en;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .alu_result_i    (alu_result_i),
    .r2_data_i       (r2_data_i),
    .writebackaddr_i (writebackaddr_i),
    .funct3_i        (funct3_i),
    .is_load_i       (is_load_i),
    .is_store_i      (is_store_i),
    .reg_write_i     (reg_write_i),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_gnt_i      (dmem_gnt_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .w_addr          (w_addr),
    .w_data          (w_data),
    .wb_en           (wb_en)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o      (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h",
             tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid_i      = 1'b0;
    alu_result_i    = '0;
    r2_data_i       = '0;
    writebackaddr_i = '0;
    funct3_i        = '0;
    is_load_i       = 1'b0;
    is_store_i      = 1'b0;
    reg_write_i     = 1'b0;
    dmem_gnt_i      = 1'b0;
    dmem_rvalid_i   = 1'b0;
    dmem_rdata_i    = '0;
  endtask

  task automatic alu_op(input logic [31:0] res,
                        input logic [4:0]  rd,
                        input logic        exp_en);
    @(negedge clk);
    ex_valid_i      = 1'b1;
    alu_result_i    = res;
    writebackaddr_i = rd;
    reg_write_i     = 1'b1;
    funct3_i        = 3'b000;
    @(negedge clk);
    ex_valid_i = 1'b0;
    chk("alu_wb_en", {31'b0, wb_en}, {31'b0, exp_en});
    if (exp_en) begin
      chk("alu_w_addr", {27'b0, w_addr}, {27'b0, rd});
      chk("alu_w_data", w_data, res);
    end
    chk("alu_busy", {31'b0, ex_ready_o}, 32'd0);
    @(negedge clk);
    chk("alu_wb_done", {31'b0, wb_en}, 32'd0);
    chk("alu_ready", {31'b0, ex_ready_o}, 32'd1);
  endtask

  task automatic do_load(input logic [2:0]  f3,
                         input logic [31:0] addr,
                         input logic [4:0]  rd,
                         input logic [31:0] rdata,
                         input int          gnt_dly,
                         input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    int held;
    held = 0;
    @(negedge clk);
    ex_valid_i      = 1'b1;
    alu_result_i    = addr;
    funct3_i        = f3;
    is_load_i       = 1'b1;
    reg_write_i     = 1'b1;
    writebackaddr_i = rd;
    r2_data_i       = $urandom;
    @(negedge clk);
    ex_valid_i = 1'b0;
    is_load_i  = 1'b0;
    for (int i = 0; i < gnt_dly; i++) begin
      if (dmem_req_o === 1'b1 && dmem_addr_o === exp_addr)
        held++;
      chk("ld_wb_quiet", {31'b0, wb_en}, 32'd0);
      @(negedge clk);
    end
    chk("ld_addr", dmem_addr_o, exp_addr);
    chk("ld_be", {28'b0, dmem_be_o}, 32'hF);
    chk("ld_we", {31'b0, dmem_we_o}, 32'd0);
    if (dmem_req_o === 1'b1) held++;
    chk("ld_req_held", held, gnt_dly + 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("ld_rsp_noreq", {31'b0, dmem_req_o}, 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
    chk("ld_wb_en", {31'b0, wb_en}, 32'd1);
    chk("ld_w_addr", {27'b0, w_addr}, {27'b0, rd});
    chk("ld_w_data", w_data, exp_data);
    @(negedge clk);
    chk("ld_wb_once", {31'b0, wb_en}, 32'd0);
    chk("ld_idle", {31'b0, ex_ready_o}, 32'd1);
  endtask

  task automatic do_store(input logic [2:0]  f3,
                          input logic [31:0] addr,
                          input logic [31:0] r2,
                          input logic [31:0] exp_addr,
                          input logic [3:0]  exp_be,
                          input logic [31:0] exp_wd);
    @(negedge clk);
    ex_valid_i      = 1'b1;
    alu_result_i    = addr;
    funct3_i        = f3;
    is_store_i      = 1'b1;
    reg_write_i     = 1'b0;
    writebackaddr_i = 5'd9;
    r2_data_i       = r2;
    @(negedge clk);
    ex_valid_i = 1'b0;
    is_store_i = 1'b0;
    chk("st_req", {31'b0, dmem_req_o}, 32'd1);
    chk("st_we", {31'b0, dmem_we_o}, 32'd1);
    chk("st_addr", dmem_addr_o, exp_addr);
    chk("st_be", {28'b0, dmem_be_o}, {28'b0, exp_be});
    chk("st_wdata", dmem_wdata_o, exp_wd);
    chk("st_wb_quiet", {31'b0, wb_en}, 32'd0);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("st_idle", {31'b0, ex_ready_o}, 32'd1);
    chk("st_noreq", {31'b0, dmem_req_o}, 32'd0);
    chk("st_no_wb", {31'b0, wb_en}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    // Reset held with random inputs.
    repeat (3) begin
      @(negedge clk);
      ex_valid_i      = 1'b1;
      alu_result_i    = $urandom;
      r2_data_i       = $urandom;
      writebackaddr_i = 5'($urandom);
      funct3_i        = 3'($urandom);
      is_load_i       = 1'($urandom);
      is_store_i      = 1'($urandom);
      reg_write_i     = 1'b1;
      dmem_gnt_i      = 1'($urandom);
      dmem_rvalid_i   = 1'($urandom);
      dmem_rdata_i    = $urandom;
    end
    chk("rst_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("rst_req", {31'b0, dmem_req_o}, 32'd0);
    chk("rst_we", {31'b0, dmem_we_o}, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_be", {28'b0, dmem_be_o}, 32'd0);
    chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst_w_addr", {27'b0, w_addr}, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
`endif
    idle_inputs();
    reset = 1'b1;

    // Stray gnt/rvalid while idle must be ignored.
    @(negedge clk);
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("stray_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("stray_wb", {31'b0, wb_en}, 32'd0);
    idle_inputs();

    // ALU ops: write on rd=5, suppressed on rd=0.
    alu_op(32'h0000_1234, 5'd5, 1'b1);
    alu_op(32'h0000_1234, 5'd0, 1'b0);
    alu_op(32'hDEAD_BEEF, 5'd31, 1'b1);

    // Loads.
    do_load(3'b000, 32'h103, 5'd7, 32'h80FF_0000, 3,
            32'h100, 32'hFFFF_FF80);
    do_load(3'b100, 32'h103, 5'd7, 32'h80FF_0000, 0,
            32'h100, 32'h0000_0080);
    do_load(3'b000, 32'h101, 5'd2, 32'h1234_8A56, 1,
            32'h100, 32'hFFFF_FF8A);
    do_load(3'b001, 32'h102, 5'd3, 32'h8001_7FFF, 0,
            32'h100, 32'hFFFF_8001);
    do_load(3'b101, 32'h102, 5'd3, 32'h8001_7FFF, 0,
            32'h100, 32'h0000_8001);
    do_load(3'b001, 32'h100, 5'd4, 32'h8001_7FFF, 0,
            32'h100, 32'h0000_7FFF);
    do_load(3'b010, 32'h400, 5'd6, 32'h1234_5678, 2,
            32'h400, 32'h1234_5678);

    // Stores.
    do_store(3'b001, 32'h202, 32'h0000_ABCD,
             32'h200, 4'b1100, 32'hABCD_ABCD);
    do_store(3'b001, 32'h200, 32'h0000_ABCD,
             32'h200, 4'b0011, 32'hABCD_ABCD);
    do_store(3'b000, 32'h201, 32'hFFFF_FF55,
             32'h200, 4'b0010, 32'h5555_5555);
    do_store(3'b000, 32'h203, 32'h0000_00A7,
             32'h200, 4'b1000, 32'hA7A7_A7A7);
    do_store(3'b010, 32'h208, 32'hCAFE_F00D,
             32'h208, 4'b1111, 32'hCAFE_F00D);

    // Reset while waiting for the load response.
    @(negedge clk);
    ex_valid_i      = 1'b1;
    alu_result_i    = 32'h500;
    funct3_i        = 3'b010;
    is_load_i       = 1'b1;
    reg_write_i     = 1'b1;
    writebackaddr_i = 5'd10;
    @(negedge clk);
    ex_valid_i = 1'b0;
    is_load_i  = 1'b0;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("midrst_in_rsp", {31'b0, ex_ready_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'b0, ex_ready_o}, 32'd1);
    reset         = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("midrst_no_wb", {31'b0, wb_en}, 32'd0);
    chk("midrst_idle", {31'b0, ex_ready_o}, 32'd1);
    @(negedge clk);
    chk("midrst_no_wb2", {31'b0, wb_en}, 32'd0);
    idle_inputs();

    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    ex_valid_i      = 1'b1;
    alu_result_i    = 32'h301;
    funct3_i        = 3'b010;
    is_load_i       = 1'b1;
    reg_write_i     = 1'b1;
    writebackaddr_i = 5'd8;
    chk("mis_pre", {31'b0, misalign_o}, 32'd0);
    @(negedge clk);
    idle_inputs();
    chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
    chk("mis_noreq", {31'b0, dmem_req_o}, 32'd0);
    chk("mis_ready", {31'b0, ex_ready_o}, 32'd1);
    chk("mis_no_wb", {31'b0, wb_en}, 32'd0);
    @(negedge clk);
    chk("mis_once", {31'b0, misalign_o}, 32'd0);
    chk("mis_noreq2", {31'b0, dmem_req_o}, 32'd0);
    chk("mis_no_wb2", {31'b0, wb_en}, 32'd0);
`else
    do_load(3'b010, 32'h301, 5'd8, 32'hCAFE_F00D, 0,
            32'h300, 32'hCAFE_F00D);
`endif

    alu_op(32'h0000_0042, 5'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately, deasserts synchronously to clk.
REQ-003 SHALL have: ex_valid_i in 1 EX result valid; ex_ready_o out 1 stage can accept.
REQ-004 SHALL have: alu_result_i in 32 ALU result / memory address; r2_data_i in 32 store data; writebackaddr_i in 5 rd; funct3_i in 3 access size/sign.
REQ-005 SHALL have: is_load_i in 1; is_store_i in 1; reg_write_i in 1 instruction writes rd.
REQ-006 SHALL have: dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out 32; dmem_wdata_o out 32; dmem_be_o out 4; dmem_gnt_i in 1; dmem_rvalid_i in 1; dmem_rdata_i in 32.
REQ-007 SHALL have: w_addr out 5, w_data out 32, wb_en out 1, the register-file write port feeding decode.
REQ-008 SHALL have: misalign_o out 1, present only under MISALIGN_TRAP_EN.

Function
REQ-009 SHALL implement FSM IDLE, REQ, RSP, WB; ex_ready_o = 1 only in IDLE.
REQ-010 IDLE: on ex_valid_i=1, SHALL register all EX inputs; load/store -> REQ, otherwise -> WB.
REQ-011 REQ: SHALL hold dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i=1; on gnt store -> IDLE, load -> RSP.
REQ-012 dmem_addr_o SHALL equal {alu_result[31:2],2'b00}; dmem_we_o = 1 for stores only.
REQ-013 Store be/wdata: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4; SH be=addr[1]?1100:0011, wdata=half replicated x2; SW be=1111, wdata=r2_data.
REQ-014 Load be SHALL be 1111.
REQ-015 RSP: on dmem_rvalid_i=1 SHALL capture aligned data -> WB; LB/LH sign-extend, LBU/LHU zero-extend, byte/half selected by addr[1:0]/addr[1]; LW unchanged.
REQ-016 WB: wb_en=1 for exactly one cycle, w_addr=registered rd, w_data=load data or ALU result; then -> IDLE.
REQ-017 wb_en SHALL be 0 when reg_write=0 or rd=0 (FSM still passes through WB).
REQ-018 Latency: ALU op accepted cycle N -> wb_en cycle N+1; load with gnt in cycle of first request and rvalid next cycle -> wb_en N+3.
REQ-019 dmem_rvalid_i outside RSP and dmem_gnt_i outside REQ SHALL be ignored.
REQ-020 wb_en, dmem_req_o SHALL be 0 in all states other than WB / REQ respectively.

Reset
REQ-021 reset=0 SHALL force IDLE; ex_ready_o then 1; dmem_req_o, dmem_we_o, wb_en, misalign_o=0; dmem_addr_o, dmem_wdata_o, w_data=0; dmem_be_o=0; w_addr=0.
REQ-022 Reset mid-transaction SHALL abandon it: no writeback, a later rvalid is ignored per REQ-019.

Configuration
REQ-023 Macro MISALIGN_TRAP_EN: when defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL skip REQ, produce no write, pulse misalign_o=1 one cycle after acceptance, return to IDLE.
REQ-024 Without MISALIGN_TRAP_EN, misalign_o SHALL not exist; offending low address bits SHALL be ignored (half uses addr[1], word uses none) and the access proceeds normally.

Verification
REQ-025 Reset: hold reset=0 with random inputs -> all outputs per REQ-021, ex_ready_o=1.
REQ-026 ALU op: alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_en=1, w_addr=5, w_data=0x0000_1234; rd=0 repeat -> wb_en=0.
REQ-027 LB addr=0x103, rdata=0x80FF_0000, gnt delayed 3 cycles -> req held 4 cycles, addr=0x100, w_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-028 SH addr=0x202, r2=0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, we=1, gnt -> IDLE, wb_en never 1.
REQ-029 Load then reset=0 while in RSP, rvalid after release -> no wb_en, FSM IDLE.
REQ-030 With MISALIGN_TRAP_EN, LW addr=0x301 -> misalign_o pulse, dmem_req_o never 1, wb_en 0; without macro same stimulus -> load from 0x300 written back.
